// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared types and defaults for the serial-to-parallel receiver
package s2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int S2P_N = 32;

endpackage

// File: rtl/s2p_out_buf.sv
// rtl/s2p_out_buf.sv - valid/ready holding register for assembled words
// A completed word is accepted only when the slot is empty or draining this cycle.
module s2p_out_buf
  import s2p_pkg::*;
#(
  parameter int N = S2P_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] word,
  input  logic         out_ready,
  output logic [N-1:0] par_out,
  output logic         out_valid,
  output logic         overrun
);

  logic accept;

  assign accept = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= load && !accept;
      if (load && accept) begin
        par_out   <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/s2p_receiver.sv
// rtl/s2p_receiver.sv - LSB-first serial-to-parallel receiver with restartable frames
// The FSM and shift register live here; word hand-off goes through s2p_out_buf.
module s2p_receiver
  import s2p_pkg::*;
#(
  parameter int N = S2P_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         enable,
  input  logic         ser_in,
  input  logic         out_ready,
  output logic [N-1:0] par_out,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun,
  output logic         frame_abort
);

  localparam int CW = $clog2(N) + 1;

  state_t        state;
  logic [CW-1:0] count;
  logic [N-1:0]  shreg;
  logic [N-1:0]  next_word;
  logic          complete;

  assign next_word = {ser_in, shreg[N-1:1]};
  assign complete  = (state == SHIFT) && enable && (count == CW'(N - 1));
  assign busy      = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      shreg       <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            count <= '0;
            shreg <= '0;
          end
        end
        SHIFT: begin
          // Completion wins over restart: the word is delivered and no abort is flagged.
          if (complete) begin
            count <= '0;
            shreg <= start ? '0 : next_word;
            state <= start ? SHIFT : IDLE;
          end else if (start) begin
            count       <= '0;
            shreg       <= '0;
            frame_abort <= 1'b1;
          end else if (enable) begin
            shreg <= next_word;
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  s2p_out_buf #(.N(N)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .word      (next_word),
    .out_ready (out_ready),
    .par_out   (par_out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_s2p_receiver.sv
// tb/tb_s2p_receiver.sv - directed self-checking bench for s2p_receiver at N=8
module tb_s2p_receiver;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         enable = 1'b0;
  logic         ser_in = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] par_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         frame_abort;

  int total = 0;
  int bad = 0;

  s2p_receiver #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .enable      (enable),
    .ser_in      (ser_in),
    .out_ready   (out_ready),
    .par_out     (par_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends bits lo..hi of v; optional idle gap between bits, optional start on the final bit.
  task automatic shift_bits(input logic [7:0] v, input int lo, input int hi,
                            input bit gapped, input bit start_last);
    for (int i = lo; i <= hi; i++) begin
      enable = 1'b1;
      ser_in = v[i];
      start  = start_last && (i == hi);
      tick();
      enable = 1'b0;
      start  = 1'b0;
      if (gapped && i < hi) tick();
    end
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;

    // Reset in the middle of a frame
    do_start();
    shift_bits(8'hFF, 0, 2, 1'b0, 1'b0);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_par", par_out, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_abort", frame_abort, 0);
    rst_n = 1'b1;
    shift_bits(8'hFF, 0, 7, 1'b0, 1'b0);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_par", par_out, 0);

    // Basic frame, ready held high
    out_ready = 1'b1;
    do_start();
    chk("basic_busy", busy, 1);
    shift_bits(8'hA5, 0, 6, 1'b0, 1'b0);
    chk("basic_early_valid", out_valid, 0);
    shift_bits(8'hA5, 7, 7, 1'b0, 1'b0);
    chk("basic_valid", out_valid, 1);
    chk("basic_par", par_out, 8'hA5);
    chk("basic_idle", busy, 0);
    tick();
    chk("basic_valid_drop", out_valid, 0);

    // Gapped strobe
    do_start();
    shift_bits(8'hA5, 0, 6, 1'b1, 1'b0);
    tick();
    chk("gap_early_valid", out_valid, 0);
    shift_bits(8'hA5, 7, 7, 1'b0, 1'b0);
    chk("gap_valid", out_valid, 1);
    chk("gap_par", par_out, 8'hA5);
    tick();

    // Backpressure and overrun
    out_ready = 1'b0;
    do_start();
    shift_bits(8'h3C, 0, 7, 1'b0, 1'b0);
    chk("bp_valid", out_valid, 1);
    chk("bp_par", par_out, 8'h3C);
    tick();
    tick();
    chk("bp_hold_valid", out_valid, 1);
    do_start();
    shift_bits(8'hFF, 0, 7, 1'b0, 1'b0);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_par", par_out, 8'h3C);
    chk("ovr_valid", out_valid, 1);
    tick();
    chk("ovr_one_cycle", overrun, 0);
    chk("ovr_par_hold", par_out, 8'h3C);
    out_ready = 1'b1;
    tick();
    chk("bp_drain", out_valid, 0);

    // Restart mid-frame
    do_start();
    shift_bits(8'hFF, 0, 2, 1'b0, 1'b0);
    do_start();
    chk("abort_pulse", frame_abort, 1);
    chk("abort_busy", busy, 1);
    tick();
    chk("abort_one_cycle", frame_abort, 0);
    shift_bits(8'h5A, 0, 7, 1'b0, 1'b0);
    chk("restart_valid", out_valid, 1);
    chk("restart_par", par_out, 8'h5A);
    tick();

    // Start coinciding with the last bit
    do_start();
    shift_bits(8'hC3, 0, 7, 1'b0, 1'b1);
    chk("coin_par", par_out, 8'hC3);
    chk("coin_valid", out_valid, 1);
    chk("coin_busy", busy, 1);
    chk("coin_abort", frame_abort, 0);
    shift_bits(8'h81, 0, 7, 1'b0, 1'b0);
    chk("coin_next_par", par_out, 8'h81);
    chk("coin_next_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
